// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - opcode/ALU/branch encodings, control bundle and decoder for the ID stage
package id_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000011;
  localparam logic [5:0] OP_AND  = 6'b000101;
  localparam logic [5:0] OP_OR   = 6'b000110;
  localparam logic [5:0] OP_NOR  = 6'b000111;
  localparam logic [5:0] OP_XOR  = 6'b001000;
  localparam logic [5:0] OP_SLA  = 6'b001001;
  localparam logic [5:0] OP_SLL  = 6'b001010;
  localparam logic [5:0] OP_SRA  = 6'b001011;
  localparam logic [5:0] OP_SRL  = 6'b001100;
  localparam logic [5:0] OP_ADDI = 6'b100000;
  localparam logic [5:0] OP_SUBI = 6'b100001;
  localparam logic [5:0] OP_LD   = 6'b100100;
  localparam logic [5:0] OP_ST   = 6'b100101;
  localparam logic [5:0] OP_BEZ  = 6'b101000;
  localparam logic [5:0] OP_BNE  = 6'b101001;
  localparam logic [5:0] OP_JMP  = 6'b101010;

  localparam logic [3:0] EXE_NOP = 4'd0;
  localparam logic [3:0] EXE_ADD = 4'd1;
  localparam logic [3:0] EXE_SUB = 4'd2;
  localparam logic [3:0] EXE_AND = 4'd3;
  localparam logic [3:0] EXE_OR  = 4'd4;
  localparam logic [3:0] EXE_NOR = 4'd5;
  localparam logic [3:0] EXE_XOR = 4'd6;
  localparam logic [3:0] EXE_SLA = 4'd7;
  localparam logic [3:0] EXE_SLL = 4'd8;
  localparam logic [3:0] EXE_SRA = 4'd9;
  localparam logic [3:0] EXE_SRL = 4'd10;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r;
    logic       mem_w;
    logic [1:0] br_type;
    logic [3:0] exe_cmd;
    logic       is_imm;
  } ctrl_t;

  // Unknown opcodes fall through to the all-zero NOP bundle.
  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_ADD; end
      OP_SUB:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_SUB; end
      OP_AND:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_AND; end
      OP_OR:   begin c.wb_en = 1'b1; c.exe_cmd = EXE_OR;  end
      OP_NOR:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_NOR; end
      OP_XOR:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_XOR; end
      OP_SLA:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_SLA; end
      OP_SLL:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_SLL; end
      OP_SRA:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_SRA; end
      OP_SRL:  begin c.wb_en = 1'b1; c.exe_cmd = EXE_SRL; end
      OP_ADDI: begin c.wb_en = 1'b1; c.exe_cmd = EXE_ADD; c.is_imm = 1'b1; end
      OP_SUBI: begin c.wb_en = 1'b1; c.exe_cmd = EXE_SUB; c.is_imm = 1'b1; end
      OP_LD:   begin c.wb_en = 1'b1; c.mem_r = 1'b1; c.exe_cmd = EXE_ADD; c.is_imm = 1'b1; end
      OP_ST:   begin c.mem_w = 1'b1; c.exe_cmd = EXE_ADD; c.is_imm = 1'b1; end
      OP_BEZ:  begin c.br_type = BR_BEZ; c.is_imm = 1'b1; end
      OP_BNE:  begin c.br_type = BR_BNE; c.is_imm = 1'b1; end
      OP_JMP:  begin c.br_type = BR_JMP; c.is_imm = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // ST and BNE still read rs2 even though their second operand is the immediate.
  function automatic logic rs2_used(input logic [5:0] op, input logic is_imm);
    return !is_imm || (op == OP_ST) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// rtl/id_stage_pipe_if.sv - IF/WB inputs and ID/EX outputs of the decode stage
interface id_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic            if_valid;
  logic            hold_in;
  logic            flush;
  logic            wb_en;
  logic [RAW-1:0]  wb_dest;
  logic [XLEN-1:0] wb_data;

  logic            hazard_stall;
  logic            id_valid;
  logic            wb_en_out;
  logic            mem_r_out;
  logic            mem_w_out;
  logic [1:0]      br_type_out;
  logic [3:0]      exe_cmd_out;
  logic [XLEN-1:0] val1;
  logic [XLEN-1:0] val2;
  logic [XLEN-1:0] st_val;
  logic [XLEN-1:0] pc_out;
  logic [RAW-1:0]  dest_out;
  logic [RAW-1:0]  src1_out;
  logic [RAW-1:0]  src2_out;

  modport master (
    output instr_in, pc_in, if_valid, hold_in, flush, wb_en, wb_dest, wb_data,
    input  hazard_stall, id_valid, wb_en_out, mem_r_out, mem_w_out, br_type_out,
           exe_cmd_out, val1, val2, st_val, pc_out, dest_out, src1_out, src2_out
  );

  modport slave (
    input  instr_in, pc_in, if_valid, hold_in, flush, wb_en, wb_dest, wb_data,
    output hazard_stall, id_valid, wb_en_out, mem_r_out, mem_w_out, br_type_out,
           exe_cmd_out, val1, val2, st_val, pc_out, dest_out, src1_out, src2_out
  );
endinterface

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - register file, two async read ports, r0 hardwired to zero
// ID_REGFILE_BYPASS_EN: same-cycle writeback data is forwarded onto matching read ports.
module id_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int RAW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RAW-1:0]  rd_idx1,
  input  logic [RAW-1:0]  rd_idx2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  input  logic            wr_en,
  input  logic [RAW-1:0]  wr_idx,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_idx != '0)) begin
      regs_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data1 = (rd_idx1 == '0) ? '0 : regs_q[rd_idx1];
    rd_data2 = (rd_idx2 == '0) ? '0 : regs_q[rd_idx2];
`ifdef ID_REGFILE_BYPASS_EN
    if (wr_en && (wr_idx != '0) && (rd_idx1 == wr_idx)) rd_data1 = wr_data;
    if (wr_en && (wr_idx != '0) && (rd_idx2 == wr_idx)) rd_data2 = wr_data;
`endif
  end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - decode stage: regfile read, decode, load-use stall, ID/EX register
// ID_REGFILE_BYPASS_EN selects write-before-read in the register file.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int              XLEN   = 32,
  parameter int              NREGS  = 32,
  parameter logic [XLEN-1:0] RST_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  id_stage_pipe_if.slave bus
);

  localparam int RAW = $clog2(NREGS);

  logic [5:0]      opcode;
  logic [RAW-1:0]  rs1, rs2, rd, dest;
  ctrl_t           ctrl;
  logic [XLEN-1:0] imm_ext, rs1_val, rs2_val;
  logic            hazard;

  logic            valid_q, valid_d;
  logic            wb_q, wb_d, mr_q, mr_d, mw_q, mw_d;
  logic [1:0]      br_q, br_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [XLEN-1:0] val1_q, val1_d, val2_q, val2_d, st_q, st_d, pc_q, pc_d;
  logic [RAW-1:0]  dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;

  assign opcode  = bus.instr_in[31:26];
  assign rs1     = bus.instr_in[21 +: RAW];
  assign rs2     = bus.instr_in[16 +: RAW];
  assign rd      = bus.instr_in[11 +: RAW];
  assign ctrl    = decode(opcode);
  assign imm_ext = XLEN'($signed(bus.instr_in[15:0]));
  assign dest    = ctrl.is_imm ? rs2 : rd;

  id_regfile #(.XLEN(XLEN), .NREGS(NREGS), .RAW(RAW)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_idx1  (rs1),
    .rd_idx2  (rs2),
    .rd_data1 (rs1_val),
    .rd_data2 (rs2_val),
    .wr_en    (bus.wb_en),
    .wr_idx   (bus.wb_dest),
    .wr_data  (bus.wb_data)
  );

  // A load in ID/EX whose target is read here cannot be forwarded in time.
  assign hazard = bus.if_valid && valid_q && mr_q && (dest_q != '0) && !bus.hold_in &&
                  ((rs1 == dest_q) || (rs2_used(opcode, ctrl.is_imm) && (rs2 == dest_q)));

  always_comb begin
    valid_d = valid_q; wb_d = wb_q; mr_d = mr_q; mw_d = mw_q; br_d = br_q; cmd_d = cmd_q;
    val1_d = val1_q; val2_d = val2_q; st_d = st_q; pc_d = pc_q;
    dest_d = dest_q; src1_d = src1_q; src2_d = src2_q;
    if (bus.flush || (!bus.hold_in && hazard)) begin
      valid_d = 1'b0; wb_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0; br_d = '0; cmd_d = '0;
      val1_d = '0; val2_d = '0; st_d = '0; pc_d = RST_PC;
      dest_d = '0; src1_d = '0; src2_d = '0;
    end else if (!bus.hold_in) begin
      valid_d = bus.if_valid;
      wb_d    = bus.if_valid && ctrl.wb_en;
      mr_d    = bus.if_valid && ctrl.mem_r;
      mw_d    = bus.if_valid && ctrl.mem_w;
      br_d    = bus.if_valid ? ctrl.br_type : 2'b00;
      cmd_d   = bus.if_valid ? ctrl.exe_cmd : 4'd0;
      val1_d  = rs1_val;
      val2_d  = ctrl.is_imm ? imm_ext : rs2_val;
      st_d    = rs2_val;
      pc_d    = bus.pc_in;
      dest_d  = dest;
      src1_d  = rs1;
      src2_d  = rs2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0; wb_q <= 1'b0; mr_q <= 1'b0; mw_q <= 1'b0; br_q <= '0; cmd_q <= '0;
      val1_q <= '0; val2_q <= '0; st_q <= '0; pc_q <= RST_PC;
      dest_q <= '0; src1_q <= '0; src2_q <= '0;
    end else begin
      valid_q <= valid_d; wb_q <= wb_d; mr_q <= mr_d; mw_q <= mw_d; br_q <= br_d; cmd_q <= cmd_d;
      val1_q <= val1_d; val2_q <= val2_d; st_q <= st_d; pc_q <= pc_d;
      dest_q <= dest_d; src1_q <= src1_d; src2_q <= src2_d;
    end
  end

  assign bus.hazard_stall = hazard;
  assign bus.id_valid     = valid_q;
  assign bus.wb_en_out    = wb_q;
  assign bus.mem_r_out    = mr_q;
  assign bus.mem_w_out    = mw_q;
  assign bus.br_type_out  = br_q;
  assign bus.exe_cmd_out  = cmd_q;
  assign bus.val1         = val1_q;
  assign bus.val2         = val2_q;
  assign bus.st_val       = st_q;
  assign bus.pc_out       = pc_q;
  assign bus.dest_out     = dest_q;
  assign bus.src1_out     = src1_q;
  assign bus.src2_out     = src2_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - scoreboard bench for id_stage_pipe (32x32 and 16-bit/8-reg builds)
module tb_id_stage_pipe;
  import id_pkg::*;

`ifdef ID_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int          id;
    logic        hz, v, wb, mr, mw;
    logic [1:0]  br;
    logic [3:0]  cmd;
    logic [31:0] v1, v2, st, pc;
    logic [4:0]  d, s1, s2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rec_id = 0;
  exp_t exp_q[$];
  exp_t exp2_q[$];

  always #5 clk = ~clk;

  id_stage_pipe_if #(.XLEN(32), .RAW(5)) bus ();
  id_stage_pipe_if #(.XLEN(16), .RAW(3)) bus2 ();

  id_stage_pipe #(.XLEN(32), .NREGS(32), .RST_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  id_stage_pipe #(.XLEN(16), .NREGS(8), .RST_PC(16'h0)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t E(input logic hz, v, wb, mr, mw, input logic [1:0] br, input logic [3:0] cmd,
                             input logic [31:0] v1, v2, st, pc, input logic [4:0] d, s1, s2);
    exp_t e;
    e.id = 0; e.hz = hz; e.v = v; e.wb = wb; e.mr = mr; e.mw = mw; e.br = br; e.cmd = cmd;
    e.v1 = v1; e.v2 = v2; e.st = st; e.pc = pc; e.d = d; e.s1 = s1; e.s2 = s2;
    return e;
  endfunction

  function automatic exp_t B(input logic hz);
    return E(hz, 0, 0, 0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endfunction

  function automatic logic [31:0] mkr(input logic [5:0] op, input logic [4:0] a, b, d);
    return {op, a, b, d, 11'b0};
  endfunction

  function automatic logic [31:0] mki(input logic [5:0] op, input logic [4:0] a, b, input logic [15:0] imm);
    return {op, a, b, imm};
  endfunction

  task automatic cmp(input string t, input exp_t e, input logic v, wb, mr, mw, input logic [1:0] br,
                     input logic [3:0] cmd, input logic [31:0] v1, v2, st, pc, input logic [4:0] d, s1, s2);
    chk({t, ".id_valid"}, v, e.v);
    chk({t, ".wb_en"}, wb, e.wb);
    chk({t, ".mem_r"}, mr, e.mr);
    chk({t, ".mem_w"}, mw, e.mw);
    chk({t, ".br_type"}, br, e.br);
    chk({t, ".exe_cmd"}, cmd, e.cmd);
    chk({t, ".val1"}, v1, e.v1);
    chk({t, ".val2"}, v2, e.v2);
    chk({t, ".st_val"}, st, e.st);
    chk({t, ".pc_out"}, pc, e.pc);
    chk({t, ".dest"}, d, e.d);
    chk({t, ".src1"}, s1, e.s1);
    chk({t, ".src2"}, s2, e.s2);
  endtask

  task automatic cyc(input logic [31:0] ins, pc, input logic iv, hold, fl, wbe, input logic [4:0] wd,
                     input logic [31:0] wdat, input exp_t e);
    @(posedge clk); #2;
    bus.instr_in = ins; bus.pc_in = pc; bus.if_valid = iv; bus.hold_in = hold; bus.flush = fl;
    bus.wb_en = wbe; bus.wb_dest = wd; bus.wb_data = wdat;
    rec_id++;
    e.id = rec_id;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && exp2_q.size() == 0) break;
      @(posedge clk); #2;
    end
    chk("drain", 64'(exp_q.size() + exp2_q.size()), 64'd0);
  endtask

  // Monitor, main DUT: hazard is checked mid-cycle, ID/EX contents just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk($sformatf("r%0d.hazard_stall", e.id), bus.hazard_stall, e.hz);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        cmp($sformatf("r%0d", e.id), e, bus.id_valid, bus.wb_en_out, bus.mem_r_out, bus.mem_w_out,
            bus.br_type_out, bus.exe_cmd_out, bus.val1, bus.val2, bus.st_val, bus.pc_out,
            bus.dest_out, bus.src1_out, bus.src2_out);
      end
    end
  end

  // Monitor, 16-bit / 8-register DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp2_q.size() != 0) begin
        e = exp2_q[0];
        chk($sformatf("n%0d.hazard_stall", e.id), bus2.hazard_stall, e.hz);
        @(posedge clk); #1;
        e = exp2_q.pop_front();
        cmp($sformatf("n%0d", e.id), e, bus2.id_valid, bus2.wb_en_out, bus2.mem_r_out, bus2.mem_w_out,
            bus2.br_type_out, bus2.exe_cmd_out, 32'(bus2.val1), 32'(bus2.val2), 32'(bus2.st_val),
            32'(bus2.pc_out), 5'(bus2.dest_out), 5'(bus2.src1_out), 5'(bus2.src2_out));
      end
    end
  end

  // Stimulus, 16-bit / 8-register DUT: field indices truncate to 3 bits, imm stays 16 bits.
  initial begin
    exp_t e;
    bus2.instr_in = '0; bus2.pc_in = '0; bus2.if_valid = 0; bus2.hold_in = 0; bus2.flush = 0;
    bus2.wb_en = 0; bus2.wb_dest = '0; bus2.wb_data = '0;
    wait (rst == 1'b0);
    @(posedge clk); #2;
    bus2.wb_en = 1; bus2.wb_dest = 3'd2; bus2.wb_data = 16'h00AB;
    e = B(0); e.id = 1; exp2_q.push_back(e);
    @(posedge clk); #2;
    bus2.wb_en = 0; bus2.if_valid = 1; bus2.pc_in = 16'h0020;
    bus2.instr_in = mki(OP_ADDI, 5'd10, 5'd13, 16'h8000);
    e = E(0, 1, 1, 0, 0, 2'd0, 4'd1, 32'hAB, 32'h8000, 0, 32'h20, 5'd5, 5'd2, 5'd5); e.id = 2;
    exp2_q.push_back(e);
    @(posedge clk); #2;
    bus2.pc_in = 16'h0021; bus2.instr_in = mki(OP_ADDI, 5'd10, 5'd13, 16'h7FFF);
    e = E(0, 1, 1, 0, 0, 2'd0, 4'd1, 32'hAB, 32'h7FFF, 0, 32'h21, 5'd5, 5'd2, 5'd5); e.id = 3;
    exp2_q.push_back(e);
    @(posedge clk); #2;
    bus2.if_valid = 0; bus2.instr_in = '0; bus2.pc_in = '0;
    e = B(0); e.id = 4; exp2_q.push_back(e);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t s7, sl;
    bus.instr_in = '0; bus.pc_in = '0; bus.if_valid = 0; bus.hold_in = 0; bus.flush = 0;
    bus.wb_en = 0; bus.wb_dest = '0; bus.wb_data = '0;
    @(posedge clk); #1;
    chk("reset.id_valid", bus.id_valid, 1'b0);
    chk("reset.pc_out", bus.pc_out, 32'h0);
    chk("reset.wb_en", bus.wb_en_out, 1'b0);
    chk("reset.hazard", bus.hazard_stall, 1'b0);
    @(negedge clk); rst = 1'b0;

    cyc(0, 0, 0, 0, 0, 1, 5'd3, 32'h1234, B(0));
    cyc(0, 0, 0, 0, 0, 1, 5'd2, 32'h10, B(0));
    cyc(mki(OP_ADDI, 3, 4, 16'hFFFF), 32'h100, 1, 0, 0, 0, 0, 0,
        E(0, 1, 1, 0, 0, 0, 1, 32'h1234, 32'hFFFFFFFF, 0, 32'h100, 4, 3, 4));
    cyc(mkr(OP_ADD, 3, 2, 5), 32'h101, 1, 0, 0, 0, 0, 0,
        E(0, 1, 1, 0, 0, 0, 1, 32'h1234, 32'h10, 32'h10, 32'h101, 5, 3, 2));
    cyc(mki(OP_LD, 2, 7, 16'h4), 32'h102, 1, 0, 0, 0, 0, 0,
        E(0, 1, 1, 1, 0, 0, 1, 32'h10, 32'h4, 0, 32'h102, 7, 2, 7));
    cyc(mkr(OP_SUB, 7, 2, 8), 32'h103, 1, 0, 0, 0, 0, 0, B(1));
    s7 = E(0, 1, 1, 0, 0, 0, 2, 0, 32'h10, 32'h10, 32'h103, 8, 7, 2);
    cyc(mkr(OP_SUB, 7, 2, 8), 32'h103, 1, 0, 0, 0, 0, 0, s7);
    for (int i = 0; i < 3; i++) cyc(mkr(OP_OR, 1, 1, 9), 32'h104, 1, 1, 0, 0, 0, 0, s7);
    cyc(mkr(OP_OR, 1, 1, 9), 32'h104, 1, 1, 1, 0, 0, 0, B(0));
    cyc(mki(OP_LD, 0, 6, 16'h8), 32'h110, 1, 0, 0, 0, 0, 0,
        E(0, 1, 1, 1, 0, 0, 1, 0, 32'h8, 0, 32'h110, 6, 0, 6));
    cyc(mki(OP_ST, 2, 6, 16'h0), 32'h111, 1, 0, 0, 0, 0, 0, B(1));
    cyc(mki(OP_ST, 2, 6, 16'h0), 32'h111, 1, 0, 0, 0, 0, 0,
        E(0, 1, 0, 0, 1, 0, 1, 32'h10, 0, 0, 32'h111, 6, 2, 6));
    cyc(mki(OP_LD, 0, 6, 16'h8), 32'h112, 1, 0, 0, 0, 0, 0,
        E(0, 1, 1, 1, 0, 0, 1, 0, 32'h8, 0, 32'h112, 6, 0, 6));
    cyc(mki(OP_ADDI, 1, 6, 16'h2), 32'h113, 1, 0, 0, 0, 0, 0,
        E(0, 1, 1, 0, 0, 0, 1, 0, 32'h2, 0, 32'h113, 6, 1, 6));
    cyc(0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF, B(0));
    cyc(mkr(OP_ADD, 0, 3, 10), 32'h120, 1, 0, 0, 0, 0, 0,
        E(0, 1, 1, 0, 0, 0, 1, 0, 32'h1234, 32'h1234, 32'h120, 10, 0, 3));
    cyc(mkr(OP_ADD, 9, 0, 11), 32'h121, 1, 0, 0, 1, 5'd9, 32'hAA,
        E(0, 1, 1, 0, 0, 0, 1, BYP ? 32'hAA : 32'h0, 0, 0, 32'h121, 11, 9, 0));
    cyc(mkr(OP_ADD, 9, 9, 12), 32'h122, 1, 0, 0, 0, 0, 0,
        E(0, 1, 1, 0, 0, 0, 1, 32'hAA, 32'hAA, 32'hAA, 32'h122, 12, 9, 9));
    cyc(mkr(OP_ADD, 5, 5, 13), 32'h123, 1, 0, 0, 1, 5'd5, 32'h77,
        E(0, 1, 1, 0, 0, 0, 1, BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0,
          32'h123, 13, 5, 5));
    cyc(mki(OP_BNE, 3, 4, 16'h5), 32'h130, 1, 0, 0, 0, 0, 0,
        E(0, 1, 0, 0, 0, 2, 0, 32'h1234, 32'h5, 0, 32'h130, 4, 3, 4));
    sl = E(0, 1, 1, 1, 0, 0, 1, 0, 0, 32'h1234, 32'h131, 3, 0, 3);
    cyc(mki(OP_LD, 0, 3, 16'h0), 32'h131, 1, 0, 0, 0, 0, 0, sl);
    cyc(mki(OP_BNE, 1, 3, 16'h2), 32'h132, 1, 1, 0, 0, 0, 0, sl);
    cyc(mki(OP_BNE, 1, 3, 16'h2), 32'h132, 1, 0, 0, 0, 0, 0, B(1));
    cyc(mki(OP_LD, 0, 3, 16'h0), 32'h133, 1, 0, 0, 0, 0, 0,
        E(0, 1, 1, 1, 0, 0, 1, 0, 0, 32'h1234, 32'h133, 3, 0, 3));
    cyc(mki(OP_BNE, 1, 3, 16'h2), 32'h132, 0, 0, 0, 0, 0, 0,
        E(0, 0, 0, 0, 0, 0, 0, 0, 32'h2, 32'h1234, 32'h132, 3, 1, 3));
    cyc(mki(OP_JMP, 0, 0, 16'h10), 32'h140, 1, 0, 0, 0, 0, 0,
        E(0, 1, 0, 0, 0, 3, 0, 0, 32'h10, 0, 32'h140, 0, 0, 0));
    cyc(mkr(6'h3F, 3, 2, 5), 32'h141, 1, 0, 0, 0, 0, 0,
        E(0, 1, 0, 0, 0, 0, 0, 32'h1234, 32'h10, 32'h10, 32'h141, 5, 3, 2));
    cyc(mkr(OP_ADD, 5, 3, 14), 32'h150, 1, 0, 0, 0, 0, 0,
        E(0, 1, 1, 0, 0, 0, 1, 32'h77, 32'h1234, 32'h1234, 32'h150, 14, 5, 3));
    drain();

    // Asynchronous reset away from any clock edge, with ADD sitting in ID/EX.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst.id_valid", bus.id_valid, 1'b0);
    chk("arst.wb_en", bus.wb_en_out, 1'b0);
    chk("arst.exe_cmd", bus.exe_cmd_out, 4'd0);
    chk("arst.val1", bus.val1, 32'h0);
    chk("arst.val2", bus.val2, 32'h0);
    chk("arst.st_val", bus.st_val, 32'h0);
    chk("arst.pc_out", bus.pc_out, 32'h0);
    chk("arst.dest", bus.dest_out, 5'd0);
    chk("arst.src1", bus.src1_out, 5'd0);
    @(negedge clk); rst = 1'b0;

    cyc(mkr(OP_ADD, 5, 3, 6), 32'h160, 1, 0, 0, 0, 0, 0,
        E(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 32'h160, 6, 5, 3));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, B(0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised next-generation instruction-decode stage: register file, decoder, immediate extension, and the ID/EX pipeline register.
- Adds behaviour the previous decode stage lacks: valid tracking, hold (stall) from downstream, flush-to-bubble, load-use hazard detection with stall request to IF, optional WB→ID bypass.
- Sits between the IF stage register and the EXE stage; consumes WB writeback.

Parameters:
- XLEN, 32, datapath/register width; immediate sign-extended to XLEN.
- NREGS, 32, register count (power of 2, ≥2); RAW = log2(NREGS) is the index width.
- RST_PC, 0, pc_out value on reset/bubble.

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous active-high reset
- instr_in  in  32  instruction from IF register; rs1=[25:21], rs2=[20:16], rd=[15:11], imm=[15:0], opcode=[31:26]; low RAW bits of each field used
- pc_in  in  XLEN  PC+1/PC from IF
- if_valid  in  1  instr_in is a real instruction
- hold_in  in  1  EXE/MEM stall; freeze ID/EX register
- flush  in  1  taken branch; next ID/EX content is a bubble
- wb_en  in  1  writeback enable
- wb_dest  in  RAW  writeback index
- wb_data  in  XLEN  writeback data
- hazard_stall  out  1  combinational; IF must hold its register
- id_valid  out  1  ID/EX holds a real instruction
- wb_en_out, mem_r_out, mem_w_out  out  1 each  control
- br_type_out  out  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- exe_cmd_out  out  4  ALU command
- val1, val2, st_val, pc_out  out  XLEN each  rs1 value, operand 2 (reg or imm), rs2 value, PC
- dest_out, src1_out, src2_out  out  RAW each  indices for forwarding unit

Behaviour:
- Reset: asynchronous active-high; all ID/EX outputs 0 (pc_out=RST_PC), id_valid=0; all registers cleared. Reset mid-stall clears hazard state immediately.
- Decode opcodes (in id_pkg): NOP 000000, ADD 000001, SUB 000011, AND 000101, OR 000110, NOR 000111, XOR 001000, SLA 001001, SLL 001010, SRA 001011, SRL 001100, ADDI 100000, SUBI 100001, LD 100100, ST 100101, BEZ 101000, BNE 101001, JMP 101010. Unknown opcodes decode as NOP.
- is_imm=1 for ADDI..JMP; dest = is_imm ? rs2 : rd.
- Control: LD sets mem_r+wb_en; ST sets mem_w; branches set br_type; wb_en=0 for ST, branches and NOP.
- rs2 usage: rs2 is "used" when !is_imm, or opcode is ST or BNE.
- Register file: write on posedge when wb_en && wb_dest≠0; index 0 reads 0 and is never written. Two combinational read ports.
- Load-use hazard: hazard_stall = if_valid & id_valid & mem_r_out & dest_out≠0 & (rs1==dest_out | (rs2 used & rs2==dest_out)) & !hold_in.
- Posedge priority: rst > flush (load bubble: all controls 0, id_valid=0) > hold_in (keep all ID/EX contents) > hazard_stall (load bubble) > normal load (id_valid=if_valid; if if_valid=0, controls forced 0).
- Latency: 1 cycle from instr_in to ID/EX outputs.
- Simultaneous flush+hold: flush wins.
- Simultaneous wb to rs1 and rs2: both reads see the write identically.

Optional Feature:
- Macro: ID_REGFILE_BYPASS_EN.
- Defined: a read index equal to wb_dest with wb_en=1 and wb_dest≠0 returns wb_data in the same cycle (write-before-read).
- Undefined: reads return the stored value; a writeback is visible the following cycle. The pipeline relies on the external forwarding unit, and the bench expects the old value.

Decomposition:
- id_pkg: opcode localparams, EXE_CMD encodings, BR_TYPE encodings, packed ctrl_t {wb_en, mem_r, mem_w, br_type, exe_cmd, is_imm}, decode function.
- Sub-module: id_regfile (parametrised XLEN/NREGS, optional bypass).
- Hazard logic and ID/EX register stay in top.

Test Plan:
- Reset mid-run: ID/EX loaded with ADD, assert rst → all outputs 0 asynchronously, reg r5 reads 0 afterwards.
- WB r3=0x1234 then ADDI r4,r3,-1 → val1=0x1234, val2=0xFFFFFFFF, dest_out=4, wb_en_out=1, exe_cmd_out matches ADD.
- LD r7 in ID/EX, SUB r8,r7,r2 in ID → hazard_stall=1, next cycle id_valid=0, bubble controls 0; following cycle SUB issues.
- hold_in=1 for 3 cycles with flush=0 → ID/EX unchanged; flush=1 & hold_in=1 → bubble.
- WB r0=0xFFFF → r0 reads 0. Same-cycle wb r9=0xAA with rs1=9: bypass defined → val1=0xAA; undefined → old value.
- XLEN=16, NREGS=8 build: ADDI imm 0x8000 → val2=0x8000, indices use 3 bits.
